// File: rtl/alu_exec_if.sv
// alu_exec_if: instruction valid/ready handshake between the issuing stage and alu_exec_ctrl.
interface alu_exec_if #(parameter int REG_AW = 2);
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        instr_op;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_rs;
    logic [7:0]        instr_imm;
    logic              instr_use_imm;
    modport master (output instr_valid, instr_op, instr_rd, instr_rs, instr_imm, instr_use_imm, input instr_ready);
    modport slave  (input instr_valid, instr_op, instr_rd, instr_rs, instr_imm, instr_use_imm, output instr_ready);
endinterface

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage sequencer feeding the 8-bit alu, writing results back and keeping Z/N/C.
module alu_exec_ctrl #(
    parameter int         REG_AW  = 2,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_if.slave         instr_if,
    output logic [3:0]        alu_op_o,
    output logic [7:0]        alu_op_a_o,
    output logic [7:0]        alu_op_b_o,
    input  logic [7:0]        alu_res_i,
    input  logic [7:0]        alu_ext_res_i,
    input  logic              alu_cb_i,
    output logic [2:0]        flags_o,
    output logic              done_o,
    output logic              illegal_o,
    input  logic [REG_AW-1:0] dbg_sel_i,
    output logic [7:0]        dbg_data_o
);
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_WB_HI = 2'd2;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_INC = 4'hC;
    localparam logic [3:0] OP_DEC = 4'hD;
    localparam logic [3:0] OP_ILL = 4'hF;

    logic [1:0]        state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [7:0]        hi_q, hi_d;
    logic [3:0]        op_q, op_d;
    logic [7:0]        a_q, a_d, b_q, b_d;
    logic [2:0]        flags_q, flags_d;
    logic              done_q, done_d, illegal_q, illegal_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic              we;
    logic [REG_AW-1:0] wa;
    logic [7:0]        wd;
    logic              carry_op;

    // alu_cb is only meaningful for the arithmetic ops; elsewhere it must not reach C
    assign carry_op = op_q inside {OP_ADD, OP_SUB, OP_CMP, OP_INC, OP_DEC};

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        hi_d      = hi_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        we        = 1'b0;
        wa        = rd_q;
        wd        = alu_res_i;
        case (state_q)
            S_IDLE: if (instr_if.instr_valid) begin
                op_d    = instr_if.instr_op;
                a_d     = regs_q[instr_if.instr_rd];
                b_d     = instr_if.instr_use_imm ? instr_if.instr_imm : regs_q[instr_if.instr_rs];
                rd_d    = instr_if.instr_rd;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q == OP_MUL) begin
                    we           = 1'b1;
                    hi_d         = alu_ext_res_i;
                    flags_d[2:1] = {({alu_ext_res_i, alu_res_i} == 16'h0000), alu_ext_res_i[7]};
                    done_d       = 1'b0;
                    state_d      = S_WB_HI;
                end else if (op_q == OP_ILL) begin
                    illegal_d = 1'b1;
                end else if (op_q != OP_NOP) begin
                    we           = (op_q != OP_CMP);
                    flags_d[2:1] = {(alu_res_i == 8'h00), alu_res_i[7]};
                    flags_d[0]   = carry_op ? alu_cb_i : flags_q[0];
                end
            end
            S_WB_HI: begin
                we      = 1'b1;
                wa      = rd_q + REG_AW'(1);
                wd      = hi_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_q      <= '0;
            hi_q      <= 8'h00;
            op_q      <= 4'h0;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            flags_q   <= 3'b000;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            hi_q      <= hi_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
        end else if (we) begin
            regs_q[wa] <= wd;
        end
    end

    assign instr_if.instr_ready = (state_q == S_IDLE);
    assign alu_op_o   = op_q;
    assign alu_op_a_o = a_q;
    assign alu_op_b_o = b_q;
    assign flags_o    = flags_q;
    assign done_o     = done_q;
    assign illegal_o  = illegal_q;
    assign dbg_data_o = regs_q[dbg_sel_i];
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed table, randomized model-checked instructions and reset/back-to-back sequences.
module tb_alu_exec_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_res, alu_ext;
    logic       alu_cb;
    logic [2:0] flags;
    logic       done, illegal;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    int checks = 0;
    int failures = 0;
    logic [7:0] mr [4];
    logic [2:0] mf;

    alu_exec_if #(.REG_AW(2)) bus ();

    alu_exec_ctrl #(.REG_AW(2), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .instr_if(bus),
        .alu_op_o(alu_op), .alu_op_a_o(alu_a), .alu_op_b_o(alu_b),
        .alu_res_i(alu_res), .alu_ext_res_i(alu_ext), .alu_cb_i(alu_cb),
        .flags_o(flags), .done_o(done), .illegal_o(illegal),
        .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_data)
    );

    always #10 clk = ~clk;

    // Stand-in alu: {cb, ext, res}; cb on non-carry ops is the inverse of current C to expose stray sampling
    function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] s;
        logic [15:0] p;
        case (op)
            4'h1: begin s = {1'b0, a} + {1'b0, b}; return {s[8], 8'h00, s[7:0]}; end
            4'h2, 4'hB: return {a < b, 8'h00, 8'(a - b)};
            4'h3: begin p = 16'(a) * 16'(b); return {~c, p}; end
            4'h4: return {~c, 8'h00, a[6:0], 1'b0};
            4'h5: return {~c, 8'h00, 1'b0, a[7:1]};
            4'h6: return {~c, 8'h00, a[0], a[7:1]};
            4'h7: return {~c, 8'h00, a[6:0], a[7]};
            4'h8: return {~c, 8'h00, a[7], a[7:1]};
            4'h9: return {~c, 8'h00, a & b};
            4'hA: return {~c, 8'h00, a ^ b};
            4'hC: return {a == 8'hFF, 8'h00, 8'(a + 8'd1)};
            4'hD: return {a == 8'h00, 8'h00, 8'(a - 8'd1)};
            4'hE: return {~c, 8'h00, b};
            default: return {~c, 16'h0000};
        endcase
    endfunction

    always_comb {alu_cb, alu_ext, alu_res} = alu_f(alu_op, alu_a, alu_b, flags[0]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mf = 3'b000;
    endtask

    // Architectural effect of one instruction; returns retire latency in cycles after accept
    task automatic model_exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                              input logic [7:0] imm, input logic use_imm, output int lat, output logic ill);
        logic [7:0] b;
        logic [16:0] r;
        b = use_imm ? imm : mr[rs];
        r = alu_f(op, mr[rd], b, mf[0]);
        lat = 1;
        ill = (op == 4'hF);
        if (op == 4'h3) begin
            mr[rd] = r[7:0];
            mr[(int'(rd) + 1) % 4] = r[15:8];
            mf[2:1] = {r[15:0] == 16'h0000, r[15]};
            lat = 2;
        end else if (op != 4'h0 && op != 4'hF) begin
            if (op != 4'hB) mr[rd] = r[7:0];
            mf[2:1] = {r[7:0] == 8'h00, r[7]};
            if (op inside {4'h1, 4'h2, 4'hB, 4'hC, 4'hD}) mf[0] = r[16];
        end
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("%s_R%0d", tag, i), dbg_data, mr[i]);
        end
        chk({tag, "_flags"}, flags, mf);
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                             input logic [7:0] imm, input logic use_imm, input int exp_lat, input logic exp_ill);
        int n;
        @(negedge clk);
        bus.instr_op = op;
        bus.instr_rd = rd;
        bus.instr_rs = rs;
        bus.instr_imm = imm;
        bus.instr_use_imm = use_imm;
        bus.instr_valid = 1'b1;
        chk("ready_idle", bus.instr_ready, 1);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        chk("ready_exec", bus.instr_ready, 0);
        n = 0;
        while (n < 4) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            chk("ready_busy", bus.instr_ready, 0);
        end
        chk("latency", n, exp_lat);
        chk("illegal", illegal, exp_ill);
        chk("ready_on_done", bus.instr_ready, 1);
        @(posedge clk);
        #1;
        chk("done_pulse", done, 0);
    endtask

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] imm;
        logic       use_imm;
        logic [1:0] chk_rd;
        logic [7:0] exp_val;
        logic [2:0] exp_flags;
        int         exp_lat;
        logic       exp_ill;
    } vec_t;
    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        int lat;
        logic ill;
        tbl[0]  = '{4'hE, 2'd1, 2'd0, 8'hF0, 1'b1, 2'd1, 8'hF0, 3'b010, 1, 1'b0};
        tbl[1]  = '{4'h1, 2'd1, 2'd0, 8'h20, 1'b1, 2'd1, 8'h10, 3'b001, 1, 1'b0};
        tbl[2]  = '{4'hE, 2'd0, 2'd0, 8'h10, 1'b1, 2'd0, 8'h10, 3'b001, 1, 1'b0};
        tbl[3]  = '{4'hB, 2'd0, 2'd1, 8'h00, 1'b0, 2'd0, 8'h10, 3'b100, 1, 1'b0};
        tbl[4]  = '{4'h2, 2'd0, 2'd0, 8'h11, 1'b1, 2'd0, 8'hFF, 3'b011, 1, 1'b0};
        tbl[5]  = '{4'hE, 2'd3, 2'd0, 8'h20, 1'b1, 2'd3, 8'h20, 3'b001, 1, 1'b0};
        tbl[6]  = '{4'h3, 2'd3, 2'd0, 8'h10, 1'b1, 2'd0, 8'h02, 3'b001, 2, 1'b0};
        tbl[7]  = '{4'hE, 2'd2, 2'd0, 8'h80, 1'b1, 2'd2, 8'h80, 3'b011, 1, 1'b0};
        tbl[8]  = '{4'h4, 2'd2, 2'd0, 8'h00, 1'b1, 2'd2, 8'h00, 3'b101, 1, 1'b0};
        tbl[9]  = '{4'hF, 2'd2, 2'd1, 8'h55, 1'b1, 2'd2, 8'h00, 3'b101, 1, 1'b1};
        tbl[10] = '{4'h0, 2'd1, 2'd0, 8'h00, 1'b1, 2'd1, 8'h10, 3'b101, 1, 1'b0};

        rst_n = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr_op = 4'h1;
        bus.instr_rd = 2'd1;
        bus.instr_rs = 2'd2;
        bus.instr_imm = 8'h77;
        bus.instr_use_imm = 1'b1;
        dbg_sel = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_ready", bus.instr_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_alu_op", alu_op, 0);
        chk("reset_alu_a", alu_a, 0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            model_exec(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, tbl[i].use_imm, lat, ill);
            run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, tbl[i].use_imm, tbl[i].exp_lat, tbl[i].exp_ill);
            dbg_sel = tbl[i].chk_rd;
            #1;
            chk($sformatf("tbl%0d_val", i), dbg_data, tbl[i].exp_val);
            chk($sformatf("tbl%0d_flags", i), flags, tbl[i].exp_flags);
            check_state($sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            logic [1:0] rd, rs;
            logic [7:0] imm;
            logic use_imm;
            op = 4'($urandom_range(0, 15));
            rd = 2'($urandom_range(0, 3));
            rs = 2'($urandom_range(0, 3));
            imm = 8'($urandom);
            use_imm = 1'($urandom_range(0, 1));
            model_exec(op, rd, rs, imm, use_imm, lat, ill);
            run_instr(op, rd, rs, imm, use_imm, lat, ill);
            check_state($sformatf("rnd%0d", i));
        end

        model_exec(4'hE, 2'd1, 2'd0, 8'hFE, 1'b1, lat, ill);
        run_instr(4'hE, 2'd1, 2'd0, 8'hFE, 1'b1, 1, 1'b0);
        dbg_sel = 2'd1;
        @(negedge clk);
        bus.instr_op = 4'hC;
        bus.instr_rd = 2'd1;
        bus.instr_use_imm = 1'b1;
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (n < 4) begin
                @(posedge clk);
                #1;
                n++;
                if (done) break;
            end
            chk($sformatf("b2b%0d_latency", k), n, 2);
            chk($sformatf("b2b%0d_R1", k), dbg_data, 8'(8'hFE + k + 1));
            chk($sformatf("b2b%0d_C", k), flags[0], (k == 1) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        chk("abort_in_exec", bus.instr_ready, 0);
        #2;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_R1", dbg_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_abort_done", done, 0);
        end
        model_reset();
        check_state("post_abort");
        chk("post_abort_ready", bus.instr_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
